period_counter: RTL

PERIOD_COUNTER -- requirements
Module: period_counter

---
 rtl/period_counter_pkg.sv | 10 +
 rtl/period_counter_sync_edge_detect.sv | 12 +
 rtl/period_counter.sv | 64 ++++++
 3 files changed

// File: rtl/period_counter_pkg.sv
// period_counter_pkg: shared counter package with FSM encodings and default parameters.
package period_counter_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAITE = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam int W_DEF            = 20;
  localparam int CLK_PER_TICK_DEF = 100;
  localparam int TBIT_DEF         = 7;
endpackage

// File: rtl/period_counter_sync_edge_detect.sv
// sync_edge_detect: two-flop synchronizer plus delay flop, one-cycle rising-edge pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic edge_o
);
  logic [2:0] sh_q, sh_d;
  always_comb sh_d = {sh_q[1:0], in};
  always_ff @(posedge clk) sh_q <= reset ? 3'b000 : sh_d;
  assign edge_o = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/period_counter.sv
// period_counter: measures si period in ticks of CLK_PER_TICK clk cycles, saturating with overflow flag.
module period_counter
  import period_counter_pkg::*;
#(
  parameter int W            = W_DEF,
  parameter int CLK_PER_TICK = CLK_PER_TICK_DEF,
  parameter int TBIT         = TBIT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         si,
  output logic         ready,
  output logic         done_tick,
  output logic [W-1:0] prd,
  output logic         ovf
);
  logic [1:0] state_q, state_d;
  logic [TBIT-1:0] pre_q, pre_d;
  logic [W-1:0] prd_q, prd_d;
  logic ovf_q, ovf_d, edge_det, wrap;
  sync_edge_detect u_sync (.clk(clk), .reset(reset), .in(si), .edge_o(edge_det));
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      prd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      prd_q   <= prd_d;
      ovf_q   <= ovf_d;
    end
  end
  always_comb
    state_d = (state_q == IDLE)  ? (start    ? WAITE : IDLE)  :
              (state_q == WAITE) ? (edge_det ? COUNT : WAITE) :
              (state_q == COUNT) ? (edge_det ? DONE  : COUNT) : IDLE;
  assign wrap = pre_q == TBIT'(CLK_PER_TICK - 1);
  // The start-edge cycle is the prescaler's first cycle, so ticks land on N = k*CLK_PER_TICK - 1.
  always_comb begin
    pre_d = pre_q;
    prd_d = prd_q;
    ovf_d = ovf_q;
    if (state_q == WAITE && edge_det) begin
      pre_d = TBIT'(1);
      prd_d = '0;
      ovf_d = 1'b0;
    end else if (state_q == COUNT && !edge_det) begin
      pre_d = wrap ? '0 : TBIT'(pre_q + 1'b1);
      if (wrap) begin
        ovf_d = ovf_q | (&prd_q);
        prd_d = (&prd_q) ? prd_q : W'(prd_q + 1'b1);
      end
    end
  end
  always_comb begin
    ready     = (state_q == IDLE) & ~reset;
    done_tick = state_q == DONE;
  end
  assign prd = prd_q;
  assign ovf = ovf_q;
endmodule
